// File: rtl/sw_stream_receiver_if.sv
// Bundle between the NIOS PIO handshake / downstream stream and the receiver.
// master = software + consumer side, slave = the receiver itself.
interface sw_stream_receiver_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [15:0]   to_hw_port;
    logic [1:0]    to_hw_sig;
    logic [1:0]    to_sw_sig;
    logic [15:0]   out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] fifo_level;

    modport master (
        output to_hw_port, to_hw_sig, out_ready,
        input  to_sw_sig, out_data, out_last, out_valid, fifo_level
    );

    modport slave (
        input  to_hw_port, to_hw_sig, out_ready,
        output to_sw_sig, out_data, out_last, out_valid, fifo_level
    );
endinterface

// File: rtl/sw_stream_receiver.sv
// Four-phase PIO handshake receiver feeding a FWFT FIFO, re-emitted as a
// valid/ready stream with out_last closing every BLOCK_WORDS-word sector.
module sw_stream_receiver #(
    parameter int DEPTH       = 16,
    parameter int BLOCK_WORDS = 256
) (
    input logic              clk,
    input logic              reset,
    sw_stream_receiver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACK   = 2'b01,
        S_BUSY  = 2'b10,
        S_ABORT = 2'b11
    } state_t;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } entry_t;

    logic [1:0]    sig_m_q, sig_s_q;
    state_t        state_q;
    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          valid_q;
    logic [CW-1:0] cnt_q;

    logic cmd_word, full, abort_req, push, pop, last_in;

    assign cmd_word  = (sig_s_q == 2'b01) || (sig_s_q == 2'b10);
    assign full      = (level_q == LW'(DEPTH));
    assign abort_req = (sig_s_q == 2'b11) && (state_q != S_ABORT);
    assign push      = !abort_req && cmd_word && !full &&
                       ((state_q == S_IDLE) || (state_q == S_BUSY));
    // A flush on abort entry swallows any pop offered in the same cycle.
    assign pop       = valid_q && bus.out_ready && !abort_req;
    assign last_in   = (sig_s_q == 2'b10) || (cnt_q == CW'(BLOCK_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_m_q <= 2'b00;
            sig_s_q <= 2'b00;
        end else begin
            sig_m_q <= bus.to_hw_sig;
            sig_s_q <= sig_m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else if (abort_req) begin
            state_q <= S_ABORT;
        end else begin
            case (state_q)
                S_IDLE:  if (cmd_word) state_q <= full ? S_BUSY : S_ACK;
                S_BUSY:  if (sig_s_q == 2'b00) state_q <= S_IDLE;
                         else if (!full)       state_q <= S_ACK;
                S_ACK:   if (sig_s_q == 2'b00) state_q <= S_IDLE;
                S_ABORT: if (sig_s_q == 2'b00) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || abort_req) begin
            cnt_q <= '0;
        end else if (push) begin
            cnt_q <= last_in ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{last: last_in, data: bus.to_hw_port};
        end
    end

    // valid lags a push by one cycle but drops on the pop that empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset || abort_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            valid_q <= (level_q - LW'(pop)) != '0;
        end
    end

    assign bus.to_sw_sig  = state_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = valid_q ? mem_q[rd_ptr_q].data : 16'h0000;
    assign bus.out_last   = valid_q ? mem_q[rd_ptr_q].last : 1'b0;
    assign bus.fifo_level = level_q;

    a_level_bound: assert property (@(posedge clk) disable iff (reset)
        level_q <= LW'(DEPTH));
    a_valid_has_data: assert property (@(posedge clk) disable iff (reset)
        valid_q |-> (level_q != '0));
endmodule
